// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: op encodings, FSM state type
// and the default datapath width.
package serial_alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // op field of alu_ctl = {ainvert, binvert, op[1:0]}
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, then AND / OR /
// full-adder sum selected by op. SLT passes the sum through so the serial
// loop can form the MSB sum and carries exactly as for ADD.
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic [1:0] op,
    input  logic       carryin,
    output logic       result,
    output logic       sum,
    output logic       carryout
);
    logic aa;
    logic bb;

    // Invert operands, compute full-adder outputs and pick the slice result
    always_comb begin
        aa       = a ^ ainvert;
        bb       = b ^ binvert;
        sum      = aa ^ bb ^ carryin;
        carryout = (aa & bb) | (aa & carryin) | (bb & carryin);
        case (op)
            OP_AND:  result = aa & bb;
            OP_OR:   result = aa | bb;
            default: result = sum;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: processes one operand bit per clock, LSB first, through a
// single 1-bit slice. After the last bit a finalisation cycle forms the
// result and flags, which are presented together with a one-cycle done pulse.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carryout
);
    // Counter runs 0..WIDTH: WIDTH bit-cycles plus the finalisation cycle
    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FINAL_CNT = CW'(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cin_msb;
    logic             cout_msb;
    logic             sum_msb;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             ainv_q;
    logic             binv_q;
    logic [1:0]       op_q;

    logic             accept;
    logic             bit_en;
    logic             s_res;
    logic             s_sum;
    logic             s_cout;
    logic             arith;
    logic             ovf_n;
    logic [WIDTH-1:0] res_n;

    // start is only honoured when no operation is in flight
    assign accept = start && (state != S_RUN);
    assign bit_en = (state == S_RUN) && (cnt != FINAL_CNT);

    serial_alu_slice u_slice (
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .ainvert  (ainv_q),
        .binvert  (binv_q),
        .op       (op_q),
        .carryin  (carry),
        .result   (s_res),
        .sum      (s_sum),
        .carryout (s_cout)
    );

    // Final result and flag values, formed from the latched MSB information
    always_comb begin
        arith = (op_q == OP_ADD) || (op_q == OP_SLT);
        ovf_n = arith & (cin_msb ^ cout_msb);
        res_n = r_sh;
        if (op_q == OP_SLT) begin
            res_n    = '0;
            res_n[0] = sum_msb ^ ovf_n;
        end
    end

    // Operand capture and per-bit shifting of operand/result shift registers
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            ainv_q <= alu_ctl[3];
            binv_q <= alu_ctl[2];
            op_q   <= alu_ctl[1:0];
        end else if (bit_en) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= {s_res, r_sh[WIDTH-1:1]};
        end
    end

    // FSM, bit counter, carry chain register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            cin_msb  <= 1'b0;
            cout_msb <= 1'b0;
            sum_msb  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
            carryout <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        carry <= alu_ctl[2];
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (cnt == FINAL_CNT) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= res_n;
                        zero     <= (res_n == '0);
                        overflow <= ovf_n;
                        carryout <= arith & cout_msb;
                    end else begin
                        carry <= s_cout;
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST_BIT) begin
                            cin_msb  <= carry;
                            cout_msb <= s_cout;
                            sum_msb  <= s_sum;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: a behavioural reference model predicts
// outputs every cycle; directed operations are also pinned to literal values.
module tb_serial_alu;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] r;
        logic         v;
        logic         c;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [3:0]   alu_ctl = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         carryout;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // reference model state
    bit   m_busy;
    bit   m_done;
    int   m_left;
    exp_t m_out;
    exp_t m_pend;

    serial_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .alu_ctl  (alu_ctl),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .carryout (carryout)
    );

    always #5 clk = ~clk;

    // Word-level ALU semantics computed with plain arithmetic
    function automatic exp_t ref_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [3:0] ctl);
        logic [W-1:0] xa;
        logic [W-1:0] yb;
        logic [W:0]   s;
        logic         v;
        exp_t         e;
        xa = ctl[3] ? ~x : x;
        yb = ctl[2] ? ~y : y;
        s  = {1'b0, xa} + {1'b0, yb} + {{W{1'b0}}, ctl[2]};
        v  = (xa[W-1] == yb[W-1]) && (s[W-1] != xa[W-1]);
        e  = '0;
        case (ctl[1:0])
            2'b00: e.r = xa & yb;
            2'b01: e.r = xa | yb;
            2'b10: begin e.r = s[W-1:0]; e.v = v; e.c = s[W]; end
            default: begin e.r = W'(s[W-1] ^ v); e.v = v; e.c = s[W]; end
        endcase
        return e;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted start yields done WIDTH+1 edges later; start is
    // ignored while an operation is in flight; reset abandons everything.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_out  <= '0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_out  <= m_pend;
                end
                m_left <= m_left - 1;
            end else if (start) begin
                m_busy <= 1'b1;
                m_left <= W + 1;
                m_pend <= ref_alu(a, b, alu_ctl);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     W'(busy),     W'(m_busy));
            chk("done",     W'(done),     W'(m_done));
            chk("result",   result,       m_out.r);
            chk("zero",     W'(zero),     W'(m_out.r == '0));
            chk("overflow", W'(overflow), W'(m_out.v));
            chk("carryout", W'(carryout), W'(m_out.c));
        end
    end

    task automatic wait_done(input int poke, output int lat);
        lat = 0;
        for (int i = 1; i <= 3 * W; i++) begin
            @(negedge clk);
            if (poke != 0 && i == poke) begin
                a       = $urandom();
                b       = $urandom();
                alu_ctl = 4'($urandom_range(0, 15));
                start   = 1'b1;
            end else if (poke != 0 && i == poke + 1) begin
                start = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: no done within %0d cycles", 3 * W);
        end
        start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [3:0] tc, input bit lit,
                          input logic [W-1:0] er, input logic ev, input logic ec,
                          input logic ez, input int poke);
        int lat;
        a       = ta;
        b       = tb_;
        alu_ctl = tc;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom();
        b     = $urandom();
        wait_done(poke, lat);
        if (lit) begin
            chk("lit_latency",  W'(lat),      W'(W + 1));
            chk("lit_result",   result,       er);
            chk("lit_overflow", W'(overflow), W'(ev));
            chk("lit_carryout", W'(carryout), W'(ec));
            chk("lit_zero",     W'(zero),     W'(ez));
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom());
        endcase
    endfunction

    initial begin
        exp_t e;
        int   lat;
        bit   seen;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;

        // pin the model against hand-computed values
        e = ref_alu(32'd5, 32'd3, 4'b0010);
        chk("model_add", e.r, 32'd8);
        e = ref_alu(32'hFFFF_FFFF, 32'd1, 4'b0111);
        chk("model_slt", e.r, 32'd1);
        chk("model_slt_c", W'(e.c), 32'd1);
        e = ref_alu(32'h7FFF_FFFF, 32'd1, 4'b0010);
        chk("model_ovf", W'(e.v), 32'd1);

        // reset values
        chk("rst_result",   result,       32'd0);
        chk("rst_zero",     W'(zero),     32'd1);
        chk("rst_busy",     W'(busy),     32'd0);
        chk("rst_done",     W'(done),     32'd0);
        chk("rst_overflow", W'(overflow), 32'd0);
        chk("rst_carryout", W'(carryout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed operations with literal expectations
        run_op(32'd5, 32'd3, 4'b0010, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 0);
        run_op(32'd3, 32'd5, 4'b0110, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'd1, 4'b0010, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 4'b0111, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 0);
        run_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b1100, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 0);

        // start pulsed in RUN cycle 10 must be ignored
        run_op(32'h0000_1234, 32'h0000_1111, 4'b0010, 1'b1, 32'h0000_2345, 1'b0, 1'b0, 1'b0, 10);

        // start held through DONE: back-to-back operation
        a = 32'd100; b = 32'd23; alu_ctl = 4'b0010; start = 1'b1;
        @(negedge clk);
        a = 32'hFF00_FF00; b = 32'h0FF0_0FF0; alu_ctl = 4'b0001;
        wait_done(0, lat);
        chk("b2b_lat1", W'(lat), W'(W + 1));
        chk("b2b_res1", result, 32'd123);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", W'(busy), 32'd1);
        wait_done(0, lat);
        chk("b2b_lat2", W'(lat), W'(W + 1));
        chk("b2b_res2", result, 32'hFFF0_FFF0);

        // reset in RUN cycle 16 abandons the operation
        a = 32'h10; b = 32'h20; alu_ctl = 4'b0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_result", result,       32'd0);
        chk("mid_rst_zero",   W'(zero),     32'd1);
        chk("mid_rst_busy",   W'(busy),     32'd0);
        chk("mid_rst_done",   W'(done),     32'd0);
        chk("mid_rst_ovf",    W'(overflow), 32'd0);
        chk("mid_rst_cout",   W'(carryout), 32'd0);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("no_done_after_rst", W'(seen), 32'd0);

        // first start after reset is accepted normally
        run_op(32'd7, 32'd9, 4'b0010, 1'b1, 32'd16, 1'b0, 1'b0, 1'b0, 0);

        // randomized operations, including back-to-back when the gap is zero
        for (int k = 0; k < 40; k++) begin
            run_op(pick(), pick(), 4'($urandom_range(0, 15)), 1'b0, '0, 1'b0, 1'b0, 1'b0,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
